// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl_pkg: shared state encoding, default SPI opcodes and rv32e memory-size encoding
package spi_mem_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_RELEASE, S_DONE} state_t;
    localparam logic [7:0] DEF_CMD_READ  = 8'h03;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;
    typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_t;
    function automatic logic [2:0] size_bytes(mem_size_t s);
        return s == MEM_WORD ? 3'd4 : s == MEM_HALF ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/spi_mem_ctrl_bit_clock.sv
// spi_bit_clock: CLK_DIV divider producing mode-0 sclk plus one-cycle rise/fall strobes
module spi_bit_clock #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic tick;
    assign tick = en && cnt == CW'(CLK_DIV - 1);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI memory master with start/done handshake serving fetches and loads/stores
module spi_mem_ctrl
    import spi_mem_ctrl_pkg::*;
#(
    parameter int NUM_CS    = 2,
    parameter int ADDR_W    = 24,
    parameter int CLK_DIV   = 1,
    parameter int MAX_BYTES = 4,
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    localparam int CS_BITS  = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_request,
    input  logic                      is_write,
    input  logic [2:0]                num_bytes,
    input  logic [ADDR_W+CS_BITS-1:0] target_address,
    input  logic [31:0]               write_value,
    output logic [31:0]               fetched_data,
    output logic                      request_done,
    output logic                      error,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    output logic [NUM_CS-1:0]         cs_n,
    input  logic                      miso
);
    localparam int FW    = 8 + ADDR_W + 32;
    localparam int CNT_W = $clog2(8 + ADDR_W + 8 * MAX_BYTES);

    state_t             state;
    logic               run, rd, rise, fall, legal;
    logic [CNT_W-1:0]   bit_cnt, last_bit;
    logic [FW-1:0]      frame;
    logic [CS_BITS-1:0] idx;
    logic [7:0]         cmd;
    logic [31:0]        wdata;
    logic [4:0]         dpos;

    assign idx   = target_address[ADDR_W +: CS_BITS];
    assign legal = num_bytes != 3'd0 && num_bytes <= 3'(MAX_BYTES) && 32'(idx) < NUM_CS;
    assign cmd   = is_write ? CMD_WRITE : CMD_READ;
    // write data is low-aligned on the port but must leave the shifter MSB first
    assign wdata = is_write ? write_value << (6'd32 - {num_bytes, 3'b000}) : 32'd0;
    assign dpos  = 5'(bit_cnt - CNT_W'(8 + ADDR_W));
    assign busy  = state != S_IDLE;

    spi_bit_clock #(.CLK_DIV(CLK_DIV)) u_bit_clock (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run),
        .sclk (sclk),
        .rise (rise),
        .fall (fall)
    );

    // run is low for one setup cycle after cs assert and one hold cycle after the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            run          <= 1'b0;
            rd           <= 1'b0;
            bit_cnt      <= '0;
            last_bit     <= '0;
            frame        <= '0;
            cs_n         <= '1;
            mosi         <= 1'b0;
            request_done <= 1'b0;
            error        <= 1'b0;
            fetched_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_request && !request_done) begin
                    rd       <= !is_write;
                    bit_cnt  <= '0;
                    last_bit <= CNT_W'(8 + ADDR_W - 1) + CNT_W'({num_bytes, 3'b000});
                    if (legal) begin
                        state        <= S_CMD;
                        cs_n         <= ~(NUM_CS'(1) << idx);
                        frame        <= {cmd, target_address[ADDR_W-1:0], wdata};
                        mosi         <= cmd[7];
                        fetched_data <= '0;
                    end else begin
                        state        <= S_DONE;
                        request_done <= 1'b1;
                        error        <= 1'b1;
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    if (!run && state == S_CMD) run <= 1'b1;
                    if (!run && state == S_DATA) begin
                        state <= S_RELEASE;
                        cs_n  <= '1;
                    end
                    if (rise && rd && state == S_DATA) fetched_data[~dpos] <= miso;
                    if (fall) begin
                        frame   <= frame << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        mosi    <= frame[FW-2];
                        if (bit_cnt == last_bit) begin
                            run  <= 1'b0;
                            mosi <= 1'b0;
                        end else if (bit_cnt == CNT_W'(7)) begin
                            state <= S_ADDR;
                        end else if (bit_cnt == CNT_W'(7 + ADDR_W)) begin
                            state <= S_DATA;
                        end
                    end
                end
                S_RELEASE: begin
                    state        <= S_DONE;
                    request_done <= 1'b1;
                end
                S_DONE: if (!start_request) begin
                    state        <= S_IDLE;
                    request_done <= 1'b0;
                    error        <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: scoreboard bench over three spi_mem_ctrl configurations
module tb_spi_mem_ctrl;
    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          done_cyc;
        logic [63:0] frame;
        int          flen;
        logic [1:0]  csm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = '0;
    logic is_write = 1'b0;
    logic [2:0] num_bytes = '0;
    logic [24:0] taddr = '0;
    logic [31:0] wval = '0;
    logic [31:0] dev = '0;
    wire miso;
    wire [2:0] done, err, busy, sclk, mosi;
    wire [2:0][31:0] fd;
    wire [2:0][1:0] cs;
    wire cs_c;
    assign cs[2] = {1'b1, cs_c};

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int bidx = 0;
    logic sq = 1'b0;
    exp_t q[$];
    exp_t e;
    logic [63:0] cap[3];
    int clen[3], last_rise[3], badp[3];
    logic [1:0] csacc[3];
    logic sp[3], dp[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mem_ctrl #(.NUM_CS(2), .ADDR_W(24), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_request(start[0]), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(taddr), .write_value(wval),
        .fetched_data(fd[0]), .request_done(done[0]), .error(err[0]), .busy(busy[0]),
        .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs[0]), .miso(miso));
    spi_mem_ctrl #(.NUM_CS(2), .ADDR_W(24), .CLK_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_request(start[1]), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(taddr), .write_value(wval),
        .fetched_data(fd[1]), .request_done(done[1]), .error(err[1]), .busy(busy[1]),
        .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs[1]), .miso(miso));
    spi_mem_ctrl #(.NUM_CS(1), .ADDR_W(24), .CLK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start_request(start[2]), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(taddr), .write_value(wval),
        .fetched_data(fd[2]), .request_done(done[2]), .error(err[2]), .busy(busy[2]),
        .sclk(sclk[2]), .mosi(mosi[2]), .cs_n(cs_c), .miso(miso));

    // device on dut_a: drives dev MSB first for frame bits 32..63
    always @(posedge clk) begin
        sq <= sclk[0];
        if (&cs[0]) bidx <= 0;
        else if (sclk[0] && !sq) bidx <= bidx + 1;
    end
    assign miso = (bidx >= 32 && bidx < 64) ? dev[63-bidx] : 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] xp);
        checks++;
        if (act !== xp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, xp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                cap[i] = '0; clen[i] = 0; csacc[i] = '0; badp[i] = 0; last_rise[i] = -1;
            end else begin
                csacc[i] = csacc[i] | ~cs[i];
                if (sclk[i] && !sp[i]) begin
                    cap[i] = {cap[i][62:0], mosi[i]};
                    clen[i]++;
                    if (last_rise[i] >= 0 && cyc - last_rise[i] != (i == 1 ? 4 : 2)) badp[i]++;
                    last_rise[i] = cyc;
                end
                if (done[i] && !dp[i]) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: inst %0d got done expected none", i);
                    end else begin
                        e = q.pop_front();
                        chk("inst", 64'(i), 64'(e.inst));
                        chk("fetched_data", 64'(fd[i]), 64'(e.data));
                        chk("error", 64'(err[i]), 64'(e.err));
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("frame_len", 64'(clen[i]), 64'(e.flen));
                        chk("mosi_frame", cap[i], e.frame);
                        chk("cs_used", 64'(csacc[i]), 64'(e.csm));
                        chk("cs_at_done", 64'(cs[i]), 64'h3);
                        chk("sclk_period", 64'(badp[i]), 64'd0);
                    end
                    cap[i] = '0; clen[i] = 0; csacc[i] = '0; badp[i] = 0; last_rise[i] = -1;
                end
            end
            sp[i] = sclk[i];
            dp[i] = done[i];
        end
    end

    task automatic issue(int i, logic w, logic [2:0] nb, logic [24:0] a, logic [31:0] wv,
                         logic [31:0] xd, logic xe, int lat, logic [63:0] xf, int fl,
                         logic [1:0] xc, int hold);
        exp_t x;
        int n;
        @(negedge clk);
        is_write = w; num_bytes = nb; taddr = a; wval = wv; start[i] = 1'b1;
        x = '{i, xd, xe, cyc + 1 + lat, xf, fl, xc};
        q.push_back(x);
        @(negedge clk);
        is_write = ~w; num_bytes = nb + 3'd1; taddr = ~a; wval = ~wv;
        n = 0;
        while (!done[i] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!done[i]) begin
            checks++; errors++;
            $display("FAIL done_timeout: inst %0d got no done expected done", i);
        end
        n = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!done[i] || !(&cs[i]) || sclk[i]) n++;
        end
        if (hold > 0) chk("hold_done", 64'(n), 64'd0);
        start[i] = 1'b0;
        @(negedge clk);
        chk("done_fall", 64'(done[i]), 64'd0);
        chk("busy_fall", 64'(busy[i]), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_cs", 64'(cs), 64'h3f);
        chk("rst_fd", 64'(fd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        dev = 32'h13050000;
        issue(0, 1'b0, 3'd4, {1'b0, 24'h000100}, 32'h0, 32'h13050000, 1'b0, 131,
              64'h03000100_00000000, 64, 2'b01, 10);
        dev = 32'hBEEF1234;
        issue(0, 1'b0, 3'd2, {1'b1, 24'hABCDE0}, 32'h0, 32'hBEEF0000, 1'b0, 99,
              64'h0000_03AB_CDE0_0000, 48, 2'b10, 0);
        issue(0, 1'b0, 3'd0, {1'b0, 24'h000100}, 32'h0, 32'hBEEF0000, 1'b1, 0, 64'h0, 0, 2'b00, 0);
        issue(0, 1'b1, 3'd5, {1'b0, 24'h000100}, 32'h0, 32'hBEEF0000, 1'b1, 0, 64'h0, 0, 2'b00, 0);
        issue(1, 1'b1, 3'd1, {1'b1, 24'h000010}, 32'h000000A5, 32'h0, 1'b0, 163,
              64'h00_0000_0200_0010_A5, 40, 2'b10, 0);
        issue(1, 1'b1, 3'd3, {1'b0, 24'h123456}, 32'hFFC0FFEE, 32'h0, 1'b0, 227,
              64'h0002_1234_56C0_FFEE, 56, 2'b01, 0);
        issue(2, 1'b0, 3'd1, {1'b1, 24'h000000}, 32'h0, 32'h0, 1'b1, 0, 64'h0, 0, 2'b00, 0);
        // abort a read in the address phase
        @(negedge clk);
        is_write = 1'b0; num_bytes = 3'd4; taddr = {1'b0, 24'h00ABCD}; start[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 64'(busy[0]), 64'd1);
        chk("pre_rst_cs", 64'(cs[0]), 64'h2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cs", 64'(cs[0]), 64'h3);
        chk("abort_sclk", 64'(sclk[0]), 64'd0);
        chk("abort_done", 64'(done[0]), 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        start[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        dev = 32'hCAFEF00D;
        issue(0, 1'b0, 3'd4, {1'b0, 24'h00ABCD}, 32'h0, 32'hCAFEF00D, 1'b0, 131,
              64'h0300ABCD_00000000, 64, 2'b01, 0);
        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
